// File: rtl/design_08_pkg.sv
// design_08_pkg: shared definitions for the design_08 scheduler slice.
//   W_DEF, N_DEF, LAT_DEF, DEPTH_DEF : default parameter values
//   ID_W                              : requester ID width for the default N
//   rsp_t                             : response FIFO entry {id, data}
package design_08_pkg;
  localparam int W_DEF     = 16;
  localparam int N_DEF     = 4;
  localparam int LAT_DEF   = 1;
  localparam int DEPTH_DEF = 4;
  localparam int ID_W      = $clog2(N_DEF);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [W_DEF-1:0] data;
  } rsp_t;
endpackage

// File: rtl/design_08_sched_if.sv
// design_08_sched_if: requester and response handshakes of the scheduler.
//   req_valid/req_ready : per-requester valid/ready (ready is a one-hot grant)
//   req_a/req_b         : per-requester operands, requester i in [i]
//   rsp_valid/rsp_ready : response FIFO head handshake
//   rsp_id/rsp_data     : requester ID and result at the FIFO head
// master = requesters + response consumer, slave = scheduler.
interface design_08_sched_if
  import design_08_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/design_08_rsp_fifo.sv
// design_08_rsp_fifo: DEPTH-entry circular FIFO with show-ahead head.
//   push/push_data : write an entry (dropped if full)
//   pop            : retire the head (ignored if empty)
//   head           : current head entry, all-zero while empty
//   empty/full     : occupancy flags
module design_08_rsp_fifo
  import design_08_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = rsp_t
)(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Zero the head while empty so response outputs read 0 when idle/reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; the head is masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/design_08_sched.sv
// design_08_sched: round-robin scheduler sharing one datapath among N
// requesters, with credit-limited issue and an ID-tagged response FIFO.
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : requester valid/ready/operands, response handshake
//   dp_start      : issue pulse to the datapath
//   dp_a/dp_b     : granted operands, 0 when idle
//   dp_y          : datapath result, valid LAT cycles after issue
module design_08_sched
  import design_08_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  design_08_sched_if.slave  bus,
  output logic              dp_start,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  input  logic [W-1:0]      dp_y
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } ent_t;

  logic [IDW-1:0]          ptr, win;
  logic                    any, issue_ok, issue, pop;
  logic [CW-1:0]           outstanding;
  logic [LAT:1]            vld_q;
  logic [LAT:1][IDW-1:0]   id_q;
  logic [LAT:0]            vld_pipe;
  logic [LAT:0][IDW-1:0]   id_pipe;
  logic                    fifo_push, fifo_empty, fifo_full;
  ent_t                    fifo_in, fifo_head;

  // Scan from the lowest priority up so the first valid after ptr wins last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (bus.req_valid[(int'(ptr) + i) % N]) begin
        win = IDW'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
  end

  // Credits cover in-flight ops plus FIFO entries, so a push never finds the
  // FIFO full. rst_n gating keeps every output at 0 while reset is held.
  assign issue_ok = rst_n & (outstanding < CW'(DEPTH));
  assign issue    = issue_ok & any;
  assign pop      = bus.rsp_valid & bus.rsp_ready;

  assign bus.req_ready = issue ? (N'(1) << win) : '0;
  assign dp_start      = issue;
  assign dp_a          = issue ? bus.req_a[win] : '0;
  assign dp_b          = issue ? bus.req_b[win] : '0;

  // Stage 0 is the issuing cycle itself; stage LAT lines up with dp_y.
  assign vld_pipe = {vld_q, issue};
  assign id_pipe  = {id_q, win};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      outstanding <= '0;
      vld_q       <= '0;
      id_q        <= '0;
    end else begin
      if (issue) ptr <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
      if (issue && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !issue) outstanding <= outstanding - 1'b1;
      vld_q <= vld_pipe[LAT-1:0];
      id_q  <= id_pipe[LAT-1:0];
    end
  end

  assign fifo_push    = vld_pipe[LAT];
  assign fifo_in.id   = id_pipe[LAT];
  assign fifo_in.data = dp_y;

  design_08_rsp_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_id    = fifo_head.id;
  assign bus.rsp_data  = fifo_head.data;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full));
endmodule

// File: tb/tb_design_08_sched.sv
module tb_design_08_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dp_start;
  logic [15:0] dp_a, dp_b, dp_y;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  design_08_sched_if #(.W(16), .N(4)) ifc ();

  design_08_sched #(.W(16), .N(4), .LAT(1), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .dp_start (dp_start),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_y     (dp_y)
  );

  function automatic logic [15:0] f(input logic [15:0] a, input logic [15:0] b);
    return 16'(a * b) + (a ^ 16'h5a5a);
  endfunction

  // One-cycle datapath: captures on dp_start, result valid next cycle.
  always_ff @(posedge clk) begin
    if (dp_start) dp_y <= f(dp_a, dp_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  a_tb_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(dut.fifo_push && dut.fifo_full));

  // Reference model: a queue of every issued-but-not-consumed op, each tagged
  // with the cycle from which it may be seen at the response head.
  typedef struct { int id; logic [15:0] y; int vis; } op_t;
  op_t q[$];
  int  m_ptr = 0;
  int  mcyc  = 0;

  always @(negedge clk) begin : model
    int          win;
    logic        e_issue, e_rv;
    logic [3:0]  e_rdy;
    logic [1:0]  e_id;
    logic [15:0] e_a, e_b, e_d;
    win = -1;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (win < 0 && ifc.req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    end
    e_issue = rst_n && (win >= 0) && (q.size() < 4);
    e_rdy   = e_issue ? 4'(1 << win) : 4'd0;
    e_a     = e_issue ? ifc.req_a[win] : 16'd0;
    e_b     = e_issue ? ifc.req_b[win] : 16'd0;
    e_rv    = rst_n && (q.size() > 0) && (q[0].vis <= mcyc);
    e_id    = e_rv ? 2'(q[0].id) : 2'd0;
    e_d     = e_rv ? q[0].y : 16'd0;
    chk("m_req_ready", 32'(ifc.req_ready), 32'(e_rdy));
    chk("m_dp_start",  32'(dp_start),      32'(e_issue));
    chk("m_dp_a",      32'(dp_a),          32'(e_a));
    chk("m_dp_b",      32'(dp_b),          32'(e_b));
    chk("m_rsp_valid", 32'(ifc.rsp_valid), 32'(e_rv));
    chk("m_rsp_id",    32'(ifc.rsp_id),    32'(e_id));
    chk("m_rsp_data",  32'(ifc.rsp_data),  32'(e_d));
    if (e_rv && ifc.rsp_ready) void'(q.pop_front());
    if (e_issue) begin
      q.push_back('{win, f(e_a, e_b), mcyc + 2});
      m_ptr = (win + 1) % 4;
    end
    mcyc++;
  end

  task automatic set_in(input logic [3:0] v, input logic [15:0] a,
                        input logic [15:0] b, input logic rr);
    ifc.req_valid = v;
    ifc.rsp_ready = rr;
    for (int i = 0; i < 4; i++) begin
      ifc.req_a[i] = a + 16'(i * 256);
      ifc.req_b[i] = b + 16'(i);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] b, input logic rr);
    @(posedge clk); #1;
    set_in(v, a, b, rr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(4'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] a, b;
    logic [3:0]  rdy;
    logic [15:0] ea, eb;
  } vec_t;
  vec_t tbl[10];

  initial begin
    // Grant sequence from ptr=0 with rsp_ready=1 (credits never run out).
    tbl[0] = '{4'b0001, 16'h0010, 16'h0001, 4'b0001, 16'h0010, 16'h0001};
    tbl[1] = '{4'b1001, 16'h0020, 16'h0002, 4'b1000, 16'h0320, 16'h0005};
    tbl[2] = '{4'b1001, 16'h0030, 16'h0003, 4'b0001, 16'h0030, 16'h0003};
    tbl[3] = '{4'b0000, 16'h0040, 16'h0004, 4'b0000, 16'h0000, 16'h0000};
    tbl[4] = '{4'b0110, 16'h0050, 16'h0005, 4'b0010, 16'h0150, 16'h0006};
    tbl[5] = '{4'b0110, 16'h0060, 16'h0006, 4'b0100, 16'h0260, 16'h0008};
    tbl[6] = '{4'b0011, 16'h0070, 16'h0007, 4'b0001, 16'h0070, 16'h0007};
    tbl[7] = '{4'b1111, 16'h0080, 16'h0008, 4'b0010, 16'h0180, 16'h0009};
    tbl[8] = '{4'b1100, 16'h0090, 16'h0009, 4'b0100, 16'h0290, 16'h000b};
    tbl[9] = '{4'b1100, 16'h00a0, 16'h000a, 4'b1000, 16'h03a0, 16'h000d};

    set_in(4'hf, 16'h1234, 16'h5678, 1'b1);
    @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'h0);
    do_reset();

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].a, tbl[k].b, 1'b1);
      chk($sformatf("tbl%0d_rdy", k),   32'(ifc.req_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_start", k), 32'(dp_start),      32'(|tbl[k].rdy));
      chk($sformatf("tbl%0d_a", k),     32'(dp_a),          32'(tbl[k].ea));
      chk($sformatf("tbl%0d_b", k),     32'(dp_b),          32'(tbl[k].eb));
    end

    // Single request: grant in cycle 0, response in cycle 2.
    do_reset();
    drive(4'b0001, 16'd3, 16'd5, 1'b1);
    chk("single_rdy", 32'(ifc.req_ready), 32'h1);
    chk("single_start", 32'(dp_start), 32'h1);
    chk("single_a", 32'(dp_a), 32'd3);
    chk("single_b", 32'(dp_b), 32'd5);
    drive(4'b0000, 16'd0, 16'd0, 1'b1);
    chk("single_c1_rv", 32'(ifc.rsp_valid), 32'h0);
    drive(4'b0000, 16'd0, 16'd0, 1'b1);
    chk("single_c2_rv", 32'(ifc.rsp_valid), 32'h1);
    chk("single_c2_id", 32'(ifc.rsp_id), 32'h0);
    chk("single_c2_data", 32'(ifc.rsp_data), 32'(f(16'd3, 16'd5)));

    // All requesting, rsp_ready=1: full-rate grants and gapless responses.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'hf, 16'h1000, 16'h0010, 1'b1);
      chk($sformatf("all%0d_rdy", k), 32'(ifc.req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("all%0d_rv", k), 32'(ifc.rsp_valid), 32'h1);
        chk($sformatf("all%0d_id", k), 32'(ifc.rsp_id), 32'((k - 2) % 4));
      end
    end

    // Backpressure: four credits, then one pop frees exactly one grant.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'hf, 16'h2000, 16'h0020, 1'b0);
      chk($sformatf("bp%0d_rdy", k), 32'(ifc.req_ready), (k < 4) ? 32'(1 << k) : 32'h0);
    end
    drive(4'hf, 16'h2000, 16'h0020, 1'b1);
    chk("bp_pop_rdy", 32'(ifc.req_ready), 32'h0);
    chk("bp_pop_id", 32'(ifc.rsp_id), 32'h0);
    drive(4'hf, 16'h2000, 16'h0020, 1'b0);
    chk("bp_after_pop_rdy", 32'(ifc.req_ready), 32'h1);
    drive(4'hf, 16'h2000, 16'h0020, 1'b0);
    chk("bp_refull_rdy", 32'(ifc.req_ready), 32'h0);

    // Priority rotation.
    do_reset();
    drive(4'b0010, 16'h3000, 16'h0030, 1'b1);
    chk("rot_g1", 32'(ifc.req_ready), 32'b0010);
    drive(4'b1001, 16'h3000, 16'h0030, 1'b1);
    chk("rot_g3", 32'(ifc.req_ready), 32'b1000);
    drive(4'b1001, 16'h3000, 16'h0030, 1'b1);
    chk("rot_g0", 32'(ifc.req_ready), 32'b0001);

    // Push and pop together at full credit count, then issue+pop together.
    do_reset();
    for (int k = 0; k < 4; k++) drive(4'hf, 16'h4000, 16'h0040, 1'b0);
    drive(4'hf, 16'h4000, 16'h0040, 1'b1);
    chk("pp_full_rdy", 32'(ifc.req_ready), 32'h0);
    drive(4'hf, 16'h4000, 16'h0040, 1'b1);
    chk("pp_issue_pop_rdy", 32'(ifc.req_ready), 32'b0001);
    drive(4'hf, 16'h4000, 16'h0040, 1'b0);
    chk("pp_last_credit_rdy", 32'(ifc.req_ready), 32'b0010);
    drive(4'hf, 16'h4000, 16'h0040, 1'b0);
    chk("pp_no_credit_rdy", 32'(ifc.req_ready), 32'h0);

    // Reset with 3 outstanding / 2 queued; in-flight work must vanish.
    do_reset();
    for (int k = 0; k < 3; k++) drive(4'hf, 16'h5000, 16'h0050, 1'b0);
    drive(4'h0, 16'h5000, 16'h0050, 1'b0);
    chk("mr_pre_rv", 32'(ifc.rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    set_in(4'hf, 16'h6000, 16'h0060, 1'b1);
    #1;
    chk("mr_rdy0", 32'(ifc.req_ready), 32'h0);
    chk("mr_start0", 32'(dp_start), 32'h0);
    chk("mr_a0", 32'(dp_a), 32'h0);
    chk("mr_b0", 32'(dp_b), 32'h0);
    chk("mr_rv0", 32'(ifc.rsp_valid), 32'h0);
    chk("mr_id0", 32'(ifc.rsp_id), 32'h0);
    chk("mr_data0", 32'(ifc.rsp_data), 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_first_grant", 32'(ifc.req_ready), 32'b0001);
    chk("mr_no_stale0", 32'(ifc.rsp_valid), 32'h0);
    drive(4'h0, 16'h0, 16'h0, 1'b1);
    chk("mr_no_stale1", 32'(ifc.rsp_valid), 32'h0);
    drive(4'h0, 16'h0, 16'h0, 1'b1);
    chk("mr_new_rv", 32'(ifc.rsp_valid), 32'h1);
    chk("mr_new_id", 32'(ifc.rsp_id), 32'h0);
    chk("mr_new_data", 32'(ifc.rsp_data), 32'(f(16'h6000, 16'h0060)));

    // Random traffic against the model, light then heavy backpressure.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (c == 300) rst_n = 1'b0;
      if (c == 302) rst_n = 1'b1;
      ifc.req_valid = 4'($urandom);
      ifc.rsp_ready = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        ifc.req_a[i] = 16'($urandom);
        ifc.req_b[i] = 16'($urandom);
      end
      @(negedge clk);
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
